// File: rtl/cradle_driver.sv
// Cradle rocking driver: tick prescaler, half-period swing timer, PWM amplitude
// drive and edge-captured frequency/amplitude commands applied at swing boundaries.
// Optional soft-start ramp: define CRADLE_SOFTSTART_EN.
module cradle_driver #(
    parameter int TICK_DIV    = 1000,
    parameter int BASE_HALF   = 64,
    parameter int STEP        = 8,
    parameter int AMP_RECOVER = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fplus,
    input  logic       fmin,
    input  logic       amin,
    output logic       swing,
    output logic       pwm,
    output logic       flow,
    output logic [2:0] freq_level,
    output logic [2:0] amp_level,
    output logic       step
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = $clog2(BASE_HALF + 1);
    localparam int RW = (AMP_RECOVER > 1) ? $clog2(AMP_RECOVER + 1) : 1;

    localparam logic [2:0]    LEVEL_MAX   = 3'd7;
    localparam logic [2:0]    FREQ_RESET  = 3'd3;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] REC_LAST    = RW'(AMP_RECOVER - 1);
    localparam logic [HW-1:0] HALF_RESET  = HW'(BASE_HALF - STEP * 3);

`ifdef CRADLE_SOFTSTART_EN
    localparam logic [2:0] AMP_RESET = 3'd0;
`else
    localparam logic [2:0] AMP_RESET = 3'd7;
`endif

    // Command bit positions inside the packed command vectors.
    localparam int C_UP = 0;
    localparam int C_DN = 1;
    localparam int C_AM = 2;

    function automatic logic [HW-1:0] half_len_of(input logic [2:0] lvl);
        return HW'(BASE_HALF - STEP * int'(lvl));
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [HW-1:0] half_cnt_q, half_cnt_d;
    logic [HW-1:0] half_len_q, half_len_d;
    logic [2:0]    slot_q, slot_d;
    logic          swing_q, swing_d;
    logic          step_q, step_d;
    logic          pwm_q, pwm_d;
    logic [2:0]    freq_q, freq_d;
    logic [2:0]    amp_q, amp_d;
    logic [RW-1:0] rec_q, rec_d;
    logic [2:0]    cmd_q, cmd_d;
    logic [2:0]    cmd_prev_q, cmd_prev_d;
    logic [2:0]    pend_q, pend_d;
    logic          ramp;
`ifdef CRADLE_SOFTSTART_EN
    logic          ramp_q, ramp_d;
`endif

    logic          tick;
    logic          boundary;
    logic          full_period;
    logic [2:0]    cmd_edge;

`ifdef CRADLE_SOFTSTART_EN
    assign ramp = ramp_q;
`else
    assign ramp = 1'b0;
`endif

    // Timebase: prescaler, half-period counter, swing/step and PWM slot.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        presc_d    = presc_q + 1'b1;
        half_cnt_d = half_cnt_q;
        slot_d     = slot_q;
        tick       = (presc_q == PRESC_LAST);
        boundary   = 1'b0;

        if (tick) begin
            presc_d  = '0;
            slot_d   = slot_q + 3'd1;
            boundary = (half_cnt_q == half_len_q - 1'b1);
            half_cnt_d = boundary ? '0 : half_cnt_q + 1'b1;
        end

        swing_d     = boundary ? ~swing_q : swing_q;
        step_d      = boundary;
        full_period = boundary && swing_q;
        pwm_d       = (slot_q < amp_q);
    end

    // Command capture: rising edges set pending flags; a boundary consumes the
    // flags it sees and keeps only an edge that lands in the boundary cycle.
    always_comb begin
        cmd_d      = {amin, fmin, fplus};
        cmd_prev_d = cmd_q;
        cmd_edge   = cmd_q & ~cmd_prev_q;
        cmd_edge[C_AM] = cmd_edge[C_AM] & ~ramp;
        pend_d     = boundary ? cmd_edge : (pend_q | cmd_edge);
    end

    // Frequency level update and the half-period length it selects.
    always_comb begin
        freq_d = freq_q;
        if (boundary) begin
            if (pend_q[C_UP] && !pend_q[C_DN] && freq_q != LEVEL_MAX) begin
                freq_d = freq_q + 3'd1;
            end else if (pend_q[C_DN] && !pend_q[C_UP] && freq_q != 3'd0) begin
                freq_d = freq_q - 3'd1;
            end
        end
        half_len_d = boundary ? half_len_of(freq_d) : half_len_q;
    end

    // Amplitude: amin steps down, full periods without amin step back up.
    always_comb begin
        amp_d = amp_q;
        rec_d = rec_q;
`ifdef CRADLE_SOFTSTART_EN
        ramp_d = ramp_q;
`endif
        if (boundary) begin
            if (ramp) begin
                if (full_period) begin
                    amp_d = amp_q + 3'd1;
`ifdef CRADLE_SOFTSTART_EN
                    ramp_d = (amp_q + 3'd1 != LEVEL_MAX);
`endif
                end
            end else if (pend_q[C_AM]) begin
                rec_d = '0;
                if (amp_q != 3'd0) begin
                    amp_d = amp_q - 3'd1;
                end
            end else if (full_period) begin
                if (rec_q == REC_LAST) begin
                    rec_d = '0;
                    if (amp_q != LEVEL_MAX) begin
                        amp_d = amp_q + 3'd1;
                    end
                end else begin
                    rec_d = rec_q + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            half_cnt_q <= '0;
            half_len_q <= HALF_RESET;
            slot_q     <= '0;
            swing_q    <= 1'b0;
            step_q     <= 1'b0;
            pwm_q      <= 1'b0;
            freq_q     <= FREQ_RESET;
            amp_q      <= AMP_RESET;
            rec_q      <= '0;
            cmd_q      <= '0;
            cmd_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            presc_q    <= presc_d;
            half_cnt_q <= half_cnt_d;
            half_len_q <= half_len_d;
            slot_q     <= slot_d;
            swing_q    <= swing_d;
            step_q     <= step_d;
            pwm_q      <= pwm_d;
            freq_q     <= freq_d;
            amp_q      <= amp_d;
            rec_q      <= rec_d;
            cmd_q      <= cmd_d;
            cmd_prev_q <= cmd_prev_d;
            pend_q     <= pend_d;
        end
    end

`ifdef CRADLE_SOFTSTART_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ramp_q <= 1'b1;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`endif

    assign swing      = swing_q;
    assign step       = step_q;
    assign pwm        = pwm_q;
    assign freq_level = freq_q;
    assign amp_level  = amp_q;
    assign flow       = (freq_q == 3'd0);

endmodule

// File: tb/tb_cradle_driver.sv
// Self-checking bench for cradle_driver with TICK_DIV=2, BASE_HALF=16, STEP=2,
// AMP_RECOVER=2 (soft-start off): table of command half-periods plus hand sequences.
module tb_cradle_driver;

    localparam int LIMIT = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       fplus = 1'b0;
    logic       fmin = 1'b0;
    logic       amin = 1'b0;
    logic       swing, pwm, flow, step;
    logic [2:0] freq_level, amp_level;

    int n_checks = 0;
    int n_fail   = 0;

    cradle_driver #(
        .TICK_DIV   (2),
        .BASE_HALF  (16),
        .STEP       (2),
        .AMP_RECOVER(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .fplus     (fplus),
        .fmin      (fmin),
        .amin      (amin),
        .swing     (swing),
        .pwm       (pwm),
        .flow      (flow),
        .freq_level(freq_level),
        .amp_level (amp_level),
        .step      (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_up;      // fplus pulses issued in the half-period
        bit dn;
        bit am;
        int exp_freq;  // at the following step
        int exp_amp;
        int exp_flow;
        int exp_half;  // clk cycles of the half-period after that step
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < LIMIT);
    endtask

    task automatic pulse(input int n_up, input bit dn, input bit am);
        int n_max;
        n_max = n_up;
        if (dn && n_max < 1) n_max = 1;
        if (am && n_max < 1) n_max = 1;
        @(negedge clk);
        for (int k = 0; k < n_max; k++) begin
            fplus = (k < n_up);
            fmin  = dn && (k == 0);
            amin  = am && (k == 0);
            @(negedge clk);
            fplus = 1'b0;
            fmin  = 1'b0;
            amin  = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int hi;

        //            up dn am  freq amp flow half
        vecs[0]  = '{0, 0, 0,   3,   7,  0,   20};
        vecs[1]  = '{1, 0, 0,   4,   7,  0,   16};
        vecs[2]  = '{1, 0, 0,   5,   7,  0,   12};
        vecs[3]  = '{1, 0, 0,   6,   7,  0,    8};
        vecs[4]  = '{1, 0, 0,   7,   7,  0,    4};
        vecs[5]  = '{1, 0, 0,   7,   7,  0,    4};
        vecs[6]  = '{1, 1, 0,   7,   7,  0,    4};
        vecs[7]  = '{0, 1, 0,   6,   7,  0,    8};
        vecs[8]  = '{0, 1, 0,   5,   7,  0,   12};
        vecs[9]  = '{0, 1, 0,   4,   7,  0,   16};
        vecs[10] = '{0, 1, 0,   3,   7,  0,   20};
        vecs[11] = '{0, 1, 0,   2,   7,  0,   24};
        vecs[12] = '{0, 1, 0,   1,   7,  0,   28};
        vecs[13] = '{0, 1, 0,   0,   7,  1,   32};
        vecs[14] = '{0, 1, 0,   0,   7,  1,   32};
        vecs[15] = '{0, 0, 1,   0,   6,  1,   32};
        vecs[16] = '{0, 0, 0,   0,   6,  1,   32};
        vecs[17] = '{0, 0, 0,   0,   7,  1,   32};
        vecs[18] = '{2, 0, 0,   1,   7,  0,   28};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_swing", int'(swing), 0);
        check("rst_step", int'(step), 0);
        check("rst_pwm", int'(pwm), 0);
        check("rst_flow", int'(flow), 0);
        check("rst_freq", int'(freq_level), 3);
        check("rst_amp", int'(amp_level), 7);

        // First half-period after release: 10 ticks of 2 clk.
        reset = 1'b0;
        wait_step(n);
        check("first_step_clk", n, 20);
        check("first_swing", int'(swing), 1);
        @(negedge clk);
        check("step_one_cycle", int'(step), 0);

        hi = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("pwm_duty_amp7", hi, 14);

        // Each entry: commands in one half-period (ending 1->0), then measure the next.
        for (int i = 0; i < 19; i++) begin
            pulse(vecs[i].n_up, vecs[i].dn, vecs[i].am);
            wait_step(n);
            check($sformatf("v%0d_step_seen", i), int'(n < LIMIT), 1);
            check($sformatf("v%0d_swing", i), int'(swing), 0);
            check($sformatf("v%0d_freq", i), int'(freq_level), vecs[i].exp_freq);
            check($sformatf("v%0d_amp", i), int'(amp_level), vecs[i].exp_amp);
            check($sformatf("v%0d_flow", i), int'(flow), vecs[i].exp_flow);
            wait_step(n);
            check($sformatf("v%0d_half_clk", i), n, vecs[i].exp_half);
        end

        // amin lowers the PWM duty to 6/8.
        pulse(0, 1'b0, 1'b1);
        wait_step(n);
        check("amin_amp", int'(amp_level), 6);
        check("amin_freq", int'(freq_level), 1);
        repeat (2) @(negedge clk);
        hi = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            hi += int'(pwm);
        end
        check("pwm_duty_amp6", hi, 12);

        // Climb to level 5, then reset mid-half-period.
        for (int k = 0; k < 4; k++) begin
            pulse(1, 1'b0, 1'b0);
            wait_step(n);
        end
        check("pre_reset_freq", int'(freq_level), 5);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_freq", int'(freq_level), 3);
        check("mid_rst_amp", int'(amp_level), 7);
        check("mid_rst_swing", int'(swing), 0);
        check("mid_rst_step", int'(step), 0);
        check("mid_rst_pwm", int'(pwm), 0);
        check("mid_rst_flow", int'(flow), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_step(n);
        check("post_rst_step_clk", n, 20);
        check("post_rst_freq", int'(freq_level), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
